// File: rtl/sc_controlunit.sv
// Microprogrammed control unit for the 32-bit micro-datapath.
// Multiplies FIX0 by FIX1 through repeated addition, then loads the product into the shifter.
module sc_controlunit #(
  parameter int DATAWIDTH_DECODER_SELECTION    = 4,
  parameter int DATAWIDTH_MUX_SELECTION        = 3,
  parameter int DATAWIDTH_ALU_SELECTION        = 4,
  parameter int DATAWIDTH_REGSHIFTER_SELECTION = 2,
  parameter int MAX_ITER                       = 255
) (
  input  logic SC_CONTROLUNIT_CLOCK_50,
  input  logic SC_CONTROLUNIT_RESET_InHigh,
  input  logic SC_CONTROLUNIT_start_InLow,
  input  logic SC_CONTROLUNIT_overflow_InLow,
  input  logic SC_CONTROLUNIT_carry_InLow,
  input  logic SC_CONTROLUNIT_negative_InLow,
  input  logic SC_CONTROLUNIT_zero_InLow,
  output logic [DATAWIDTH_DECODER_SELECTION-1:0] SC_CONTROLUNIT_decoderclearselection_OutBUS,
  output logic [DATAWIDTH_DECODER_SELECTION-1:0] SC_CONTROLUNIT_decoderloadselection_OutBUS,
  output logic [DATAWIDTH_MUX_SELECTION-1:0] SC_CONTROLUNIT_muxselectionBUSA_OutBUS,
  output logic [DATAWIDTH_MUX_SELECTION-1:0] SC_CONTROLUNIT_muxselectionBUSB_OutBUS,
  output logic [DATAWIDTH_ALU_SELECTION-1:0] SC_CONTROLUNIT_aluselection_OutBUS,
  output logic SC_CONTROLUNIT_regSHIFTERclear_OutLow,
  output logic SC_CONTROLUNIT_regSHIFTERload_OutLow,
  output logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SC_CONTROLUNIT_regSHIFTERshiftselection_OutLow,
  output logic SC_CONTROLUNIT_done_OutHigh,
  output logic SC_CONTROLUNIT_error_OutHigh
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_CLR  = 4'd1,
    S_LDA  = 4'd2,
    S_LDB  = 4'd3,
    S_ADD  = 4'd4,
    S_DEC  = 4'd5,
    S_OUT  = 4'd6,
    S_DONE = 4'd7,
    S_ERR  = 4'd8
  } state_t;

  state_t state;
  state_t state_next;
  logic [1:0] clr_cnt;
  logic [7:0] iter;
  logic [7:0] iter_inc;
  logic unused_flags;

  assign unused_flags = SC_CONTROLUNIT_overflow_InLow
                      ^ SC_CONTROLUNIT_negative_InLow;
  assign iter_inc = iter + 8'd1;

  always_ff @(posedge SC_CONTROLUNIT_CLOCK_50 or posedge SC_CONTROLUNIT_RESET_InHigh) begin
    if (SC_CONTROLUNIT_RESET_InHigh) begin
      state   <= S_IDLE;
      clr_cnt <= 2'd0;
      iter    <= 8'd0;
    end else begin
      state   <= state_next;
      clr_cnt <= (state == S_CLR) ? clr_cnt + 2'd1 : 2'd0;
      if (state_next == S_CLR && state != S_CLR)
        iter <= 8'd0;
      else if (state == S_DEC)
        iter <= iter_inc;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (!SC_CONTROLUNIT_start_InLow) state_next = S_CLR;
      S_CLR:  if (clr_cnt == 2'd3) state_next = S_LDA;
      S_LDA:  state_next = S_LDB;
      S_LDB:  state_next = !SC_CONTROLUNIT_zero_InLow ? S_OUT : S_ADD;
      S_ADD:  state_next = !SC_CONTROLUNIT_carry_InLow ? S_ERR : S_DEC;
      S_DEC: begin
        if (!SC_CONTROLUNIT_zero_InLow)
          state_next = S_OUT;
        else if (iter_inc == 8'(MAX_ITER))
          state_next = S_ERR;
        else
          state_next = S_ADD;
      end
      S_OUT:  state_next = S_DONE;
      S_DONE: if (!SC_CONTROLUNIT_start_InLow) state_next = S_CLR;
      S_ERR:  if (!SC_CONTROLUNIT_start_InLow) state_next = S_CLR;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    SC_CONTROLUNIT_decoderclearselection_OutBUS    = '1;
    SC_CONTROLUNIT_decoderloadselection_OutBUS     = '1;
    SC_CONTROLUNIT_muxselectionBUSA_OutBUS         = '0;
    SC_CONTROLUNIT_muxselectionBUSB_OutBUS         = '0;
    SC_CONTROLUNIT_aluselection_OutBUS             = '0;
    SC_CONTROLUNIT_regSHIFTERclear_OutLow          = 1'b1;
    SC_CONTROLUNIT_regSHIFTERload_OutLow           = 1'b1;
    SC_CONTROLUNIT_regSHIFTERshiftselection_OutLow = '0;
    SC_CONTROLUNIT_done_OutHigh                    = 1'b0;
    SC_CONTROLUNIT_error_OutHigh                   = 1'b0;
    case (state)
      S_CLR: begin
        SC_CONTROLUNIT_decoderclearselection_OutBUS =
          DATAWIDTH_DECODER_SELECTION'(clr_cnt);
        SC_CONTROLUNIT_regSHIFTERclear_OutLow = (clr_cnt != 2'd0);
      end
      S_LDA: begin
        SC_CONTROLUNIT_muxselectionBUSA_OutBUS     = 3'b110;
        SC_CONTROLUNIT_decoderloadselection_OutBUS = 4'd0;
      end
      S_LDB: begin
        SC_CONTROLUNIT_muxselectionBUSA_OutBUS     = 3'b111;
        SC_CONTROLUNIT_decoderloadselection_OutBUS = 4'd1;
      end
      S_ADD: begin
        SC_CONTROLUNIT_muxselectionBUSA_OutBUS     = 3'd2;
        SC_CONTROLUNIT_muxselectionBUSB_OutBUS     = 3'd0;
        SC_CONTROLUNIT_aluselection_OutBUS         = 4'b0001;
        SC_CONTROLUNIT_decoderloadselection_OutBUS = 4'd2;
      end
      S_DEC: begin
        SC_CONTROLUNIT_muxselectionBUSA_OutBUS     = 3'd1;
        SC_CONTROLUNIT_aluselection_OutBUS         = 4'b0101;
        SC_CONTROLUNIT_decoderloadselection_OutBUS = 4'd1;
      end
      S_OUT: begin
        SC_CONTROLUNIT_muxselectionBUSA_OutBUS = 3'd2;
        SC_CONTROLUNIT_regSHIFTERload_OutLow   = 1'b0;
      end
      S_DONE: SC_CONTROLUNIT_done_OutHigh  = 1'b1;
      S_ERR:  SC_CONTROLUNIT_error_OutHigh = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sc_controlunit.sv
// Bench for sc_controlunit: behavioural datapath around the DUT,
// expectations from the multiply-by-addition timing rules.
module tb_sc_controlunit;

  logic clk;
  logic rst;
  logic start;
  logic start2;
  logic cy_n;
  logic zr_n;
  logic force_cy;

  logic [3:0] clr_sel, ld_sel, alu;
  logic [2:0] mux_a, mux_b;
  logic       sh_clr, sh_ld, done, error;
  logic [1:0] sh_mode;

  logic [3:0] clr2, ld2, alu2;
  logic [2:0] a2, b2;
  logic       shc2, shl2, done2, err2;
  logic [1:0] mode2;

  logic [31:0] r [4];
  logic [31:0] fix0, fix1, sh;
  logic [31:0] bus_a, bus_b;
  logic [32:0] res;

  int n_chk;
  int n_fail;

  localparam logic [23:0] DEFAULTS =
    {4'hf, 4'hf, 3'd0, 3'd0, 4'd0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0};

  sc_controlunit dut (
    .SC_CONTROLUNIT_CLOCK_50(clk),
    .SC_CONTROLUNIT_RESET_InHigh(rst),
    .SC_CONTROLUNIT_start_InLow(start),
    .SC_CONTROLUNIT_overflow_InLow(1'b1),
    .SC_CONTROLUNIT_carry_InLow(cy_n),
    .SC_CONTROLUNIT_negative_InLow(1'b1),
    .SC_CONTROLUNIT_zero_InLow(zr_n),
    .SC_CONTROLUNIT_decoderclearselection_OutBUS(clr_sel),
    .SC_CONTROLUNIT_decoderloadselection_OutBUS(ld_sel),
    .SC_CONTROLUNIT_muxselectionBUSA_OutBUS(mux_a),
    .SC_CONTROLUNIT_muxselectionBUSB_OutBUS(mux_b),
    .SC_CONTROLUNIT_aluselection_OutBUS(alu),
    .SC_CONTROLUNIT_regSHIFTERclear_OutLow(sh_clr),
    .SC_CONTROLUNIT_regSHIFTERload_OutLow(sh_ld),
    .SC_CONTROLUNIT_regSHIFTERshiftselection_OutLow(sh_mode),
    .SC_CONTROLUNIT_done_OutHigh(done),
    .SC_CONTROLUNIT_error_OutHigh(error)
  );

  // FIX1=15 never zeroes R1 within four decrements, so flags stay idle
  sc_controlunit #(.MAX_ITER(4)) dut4 (
    .SC_CONTROLUNIT_CLOCK_50(clk),
    .SC_CONTROLUNIT_RESET_InHigh(rst),
    .SC_CONTROLUNIT_start_InLow(start2),
    .SC_CONTROLUNIT_overflow_InLow(1'b1),
    .SC_CONTROLUNIT_carry_InLow(1'b1),
    .SC_CONTROLUNIT_negative_InLow(1'b1),
    .SC_CONTROLUNIT_zero_InLow(1'b1),
    .SC_CONTROLUNIT_decoderclearselection_OutBUS(clr2),
    .SC_CONTROLUNIT_decoderloadselection_OutBUS(ld2),
    .SC_CONTROLUNIT_muxselectionBUSA_OutBUS(a2),
    .SC_CONTROLUNIT_muxselectionBUSB_OutBUS(b2),
    .SC_CONTROLUNIT_aluselection_OutBUS(alu2),
    .SC_CONTROLUNIT_regSHIFTERclear_OutLow(shc2),
    .SC_CONTROLUNIT_regSHIFTERload_OutLow(shl2),
    .SC_CONTROLUNIT_regSHIFTERshiftselection_OutLow(mode2),
    .SC_CONTROLUNIT_done_OutHigh(done2),
    .SC_CONTROLUNIT_error_OutHigh(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    bus_a = 32'd0;
    case (mux_a)
      3'd0: bus_a = r[0];
      3'd1: bus_a = r[1];
      3'd2: bus_a = r[2];
      3'd3: bus_a = r[3];
      3'd6: bus_a = fix0;
      3'd7: bus_a = fix1;
      default: bus_a = 32'd0;
    endcase
  end

  always_comb begin
    bus_b = 32'd0;
    case (mux_b)
      3'd0: bus_b = r[0];
      3'd1: bus_b = r[1];
      3'd2: bus_b = r[2];
      3'd3: bus_b = r[3];
      3'd6: bus_b = fix0;
      3'd7: bus_b = fix1;
      default: bus_b = 32'd0;
    endcase
  end

  always_comb begin
    res = {1'b0, bus_a};
    case (alu)
      4'b0001: res = {1'b0, bus_a} + {1'b0, bus_b};
      4'b0101: res = {1'b0, bus_a - 32'd1};
      default: res = {1'b0, bus_a};
    endcase
    zr_n = (res[31:0] != 32'd0);
    cy_n = !(force_cy || (alu == 4'b0001 && res[32]));
  end

  always @(posedge clk) begin
    if (clr_sel < 4'd4) r[clr_sel[1:0]] <= 32'd0;
    if (ld_sel < 4'd4) r[ld_sel[1:0]] <= res[31:0];
    if (!sh_clr) sh <= 32'd0;
    else if (!sh_ld) sh <= res[31:0];
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pulses start for one sampled edge, then counts edges to done/error.
  task automatic run(input int force_add, input int limit,
                     output int done_at, output int err_at);
    int adds;
    adds = 0;
    done_at = -1;
    err_at = -1;
    @(negedge clk) start = 1'b0;
    @(posedge clk);
    @(negedge clk) start = 1'b1;
    for (int k = 1; k <= limit; k++) begin
      force_cy = 1'b0;
      if (alu == 4'b0001) begin
        adds++;
        force_cy = (adds == force_add);
      end
      @(posedge clk);
      @(negedge clk);
      force_cy = 1'b0;
      if (done && done_at < 0) done_at = k;
      if (error && err_at < 0) err_at = k;
      if (done_at >= 0 || err_at >= 0) break;
    end
  endtask

  function automatic int exp_cycles(input logic [31:0] n);
    return (n == 0) ? 7 : 2 * int'(n) + 7;
  endfunction

  initial begin
    int d, e, k, pos;
    n_chk = 0;
    n_fail = 0;
    force_cy = 1'b0;
    start = 1'b1;
    start2 = 1'b1;
    fix0 = 32'd9;
    fix1 = 32'd15;
    rst = 1'b1;
    #2;
    check("reset defaults", 64'({clr_sel, ld_sel, mux_a, mux_b, alu,
          sh_clr, sh_ld, sh_mode, done, error}), 64'(DEFAULTS));
    check("reset defaults dut4", 64'({clr2, ld2, a2, b2, alu2,
          shc2, shl2, mode2, done2, err2}), 64'(DEFAULTS));
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle holds without start", 64'(done | error), 64'd0);

    run(0, 200, d, e);
    check("9x15 done cycle", 64'(d), 64'd37);
    check("9x15 product", 64'(sh), 64'd135);

    fix1 = 32'd0;
    run(0, 200, d, e);
    check("n0 done cycle", 64'(d), 64'd7);
    check("n0 product", 64'(sh), 64'd0);

    for (int i = 0; i < 6; i++) begin
      fix0 = 32'($urandom_range(0, 65535));
      fix1 = 32'($urandom_range(0, 30));
      run(0, 200, d, e);
      check("rand done cycle", 64'(d), 64'(exp_cycles(fix1)));
      check("rand product", 64'(sh), 64'(fix0 * fix1));
      check("rand no error", 64'(e), 64'hffff_ffff_ffff_ffff);
    end

    fix0 = 32'd9;
    fix1 = 32'd15;
    run(3, 200, d, e);
    check("carry err cycle", 64'(e), 64'd11);
    check("carry no done", 64'(d), 64'hffff_ffff_ffff_ffff);
    repeat (5) @(negedge clk);
    check("error sticky", 64'(error), 64'd1);
    check("error sticky no done", 64'(done), 64'd0);
    start = 1'b0;
    @(negedge clk) start = 1'b1;
    check("restart from err clr code", 64'(clr_sel), 64'd0);
    check("restart from err shifter clr", 64'(sh_clr), 64'd0);
    check("restart clears error", 64'(error), 64'd0);
    for (k = 0; k < 200 && !done; k++) @(negedge clk);
    check("rerun after err product", 64'(sh), 64'd135);

    @(negedge clk) start = 1'b0;
    @(posedge clk);
    @(negedge clk) start = 1'b1;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid-loop reset defaults", 64'({clr_sel, ld_sel, mux_a, mux_b,
          alu, sh_clr, sh_ld, sh_mode, done, error}), 64'(DEFAULTS));
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    check("after reset idle", 64'({alu, ld_sel, done}), 64'({4'd0, 4'hf, 1'b0}));
    run(0, 200, d, e);
    check("post-reset done cycle", 64'(d), 64'd37);
    check("post-reset product", 64'(sh), 64'd135);

    // start held low in DONE: period of 38 edges, CLR codes 0..3 each pass
    start = 1'b0;
    for (k = 0; k < 116; k++) begin
      @(posedge clk);
      @(negedge clk);
      pos = k % 38;
      check("b2b done", 64'(done), 64'(pos == 37));
      if (pos < 4) check("b2b clr code", 64'(clr_sel), 64'(pos));
      if (pos == 37) check("b2b product", 64'(sh), 64'd135);
    end
    start = 1'b1;

    @(negedge clk) start2 = 1'b0;
    @(posedge clk);
    @(negedge clk) start2 = 1'b1;
    e = -1;
    d = 0;
    for (k = 1; k <= 60; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done2) d = 1;
      if (err2) begin
        e = k;
        break;
      end
    end
    check("max_iter4 err cycle", 64'(e), 64'd14);
    check("max_iter4 no done", 64'(d), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
